// File: rtl/serial_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, start/busy/done handshake.
// Optional subtract mode and signed-overflow flag when SERIAL_ADDER_SUB_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start; sum/cout hold the last result
// RUN    | one DIGIT-wide add step per edge, carry registered between steps
// DONE   | one-cycle done pulse; a start here is accepted immediately
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_SUB_EN
  ,
  output logic             ovf
`endif
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]         step_sum;
  logic [WIDTH+DIGIT-1:0] psum_cat;
  logic [WIDTH-1:0]       psum_next;
  logic                   last_step;
  logic [WIDTH-1:0]       b_eff;
  logic                   cin_eff;
  logic                   unused_psum_low;

`ifdef SERIAL_ADDER_SUB_EN
  logic ovf_next;

  // Subtraction as a + ~b + ~cin, i.e. a - b - cin in two's complement.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? ~cin : cin;
  // Top digit sits in the low bits on the last step; same-sign operands with
  // a different-sign result is exactly carry-into-MSB xor carry-out.
  assign ovf_next = (a_sh[DIGIT-1] ~^ b_sh[DIGIT-1]) & (step_sum[DIGIT-1] ^ a_sh[DIGIT-1]);
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign step_sum  = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  // New digit enters at the MSB end; the oldest bits fall off the bottom.
  assign psum_cat  = {step_sum[DIGIT-1:0], psum};
  assign psum_next = psum_cat[WIDTH+DIGIT-1:DIGIT];
  assign unused_psum_low = ^psum_cat[DIGIT-1:0];
  assign last_step = (cnt == CW'(STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b_eff;
            carry <= cin_eff;
            psum  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          carry <= step_sum[DIGIT];
          psum  <= psum_next;
          cnt   <= cnt + CW'(1);
          if (last_step) begin
            sum   <= psum_next;
            cout  <= step_sum[DIGIT];
`ifdef SERIAL_ADDER_SUB_EN
            ovf   <= ovf_next;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: three instances (8/2, 1/1, 16/4) with hand-computed results.
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // 8-bit, 2 bits per step
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub8, ovf8;
`endif
  // 1-bit, 1 bit per step
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
  // 16-bit, 4 bits per step
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_SUB_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(1), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_SUB_EN
    , .ovf()
`endif
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef SERIAL_ADDER_SUB_EN
    , .ovf()
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'h000) begin
      failures++;
      $display("FAIL reset_dut8 got busy=%b done=%b cout=%b sum=%h want all 0", busy8, done8, cout8, sum8);
    end
    checks++;
    if ({busy1, done1, cout1, sum1} !== 4'h0) begin
      failures++;
      $display("FAIL reset_dut1 got busy=%b done=%b cout=%b sum=%h want all 0", busy1, done1, cout1, sum1);
    end
    checks++;
    if ({busy16, done16, cout16, sum16} !== 19'h0) begin
      failures++;
      $display("FAIL reset_dut16 got busy=%b done=%b cout=%b sum=%h want all 0", busy16, done16, cout16, sum16);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // 0xFF + 0x01: busy for 4 cycles, done in the 5th with sum=0x00, cout=1.
  task automatic test_basic();
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'h00; b8 = 8'h00;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (busy8 !== (k < 4) || done8 !== (k == 4)) begin
        failures++;
        $display("FAIL basic_handshake cycle=%0d got busy=%b done=%b want busy=%b done=%b",
                 k, busy8, done8, k < 4, k == 4);
      end
      if (k < 4) @(negedge clk);
    end
    checks++;
    if ({cout8, sum8} !== 9'h100) begin
      failures++;
      $display("FAIL basic_result got cout=%b sum=%h want cout=1 sum=00", cout8, sum8);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || {cout8, sum8} !== 9'h100) begin
      failures++;
      $display("FAIL basic_hold got done=%b cout=%b sum=%h want done=0 cout=1 sum=00", done8, cout8, sum8);
    end
  endtask

  // WIDTH=1 behaves as a half adder: one RUN cycle, done one cycle after start.
  task automatic test_half_adder();
    logic [1:0] exp_tab [4];
    exp_tab[0] = 2'b00; exp_tab[1] = 2'b01; exp_tab[2] = 2'b01; exp_tab[3] = 2'b10;
    cin1 = 1'b0;
    for (int v = 0; v < 4; v++) begin
      a1 = 1'(v >> 1); b1 = 1'(v); start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        failures++;
        $display("FAIL half_run v=%0d got busy=%b done=%b want busy=1 done=0", v, busy1, done1);
      end
      @(negedge clk);
      checks++;
      if (done1 !== 1'b1 || {cout1, sum1} !== exp_tab[v]) begin
        failures++;
        $display("FAIL half_result v=%0d got done=%b cout=%b sum=%b want done=1 cout/sum=%b",
                 v, done1, cout1, sum1, exp_tab[v]);
      end
    end
    @(negedge clk);
  endtask

  // start held high: operands changed while busy must not disturb the first result.
  task automatic test_back_to_back();
    logic exp_done;
    a8 = 8'h3C; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
    for (int n = 0; n < 15; n++) begin
      exp_done = (n == 4) || (n == 9) || (n == 14);
      checks++;
      if (done8 !== exp_done || busy8 !== !exp_done) begin
        failures++;
        $display("FAIL b2b_handshake n=%0d got done=%b busy=%b want done=%b busy=%b",
                 n, done8, busy8, exp_done, !exp_done);
      end
      if (n == 4) begin
        checks++;
        if ({cout8, sum8} !== 9'h092) begin
          failures++;
          $display("FAIL b2b_first got cout=%b sum=%h want cout=0 sum=92", cout8, sum8);
        end
      end
      if (n == 9 || n == 14) begin
        checks++;
        if ({cout8, sum8} !== 9'h002) begin
          failures++;
          $display("FAIL b2b_next n=%0d got cout=%b sum=%h want cout=0 sum=02", n, cout8, sum8);
        end
      end
      if (n == 14) start8 = 1'b0;
      @(negedge clk);
    end
  endtask

  // Async reset during step 2 aborts the op; the next op still works.
  task automatic test_reset_mid_op();
    bit seen;
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'h000) begin
      failures++;
      $display("FAIL midreset_clear got busy=%b done=%b cout=%b sum=%h want all 0", busy8, done8, cout8, sum8);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midreset_no_done got activity=1 want 0 after aborted op");
    end
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      if (done8 === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen || {cout8, sum8} !== 9'h003) begin
      failures++;
      $display("FAIL midreset_next got done_seen=%b cout=%b sum=%h want done_seen=1 cout=0 sum=03",
               seen, cout8, sum8);
    end
    @(negedge clk);
  endtask

  // WIDTH=16, DIGIT=4 vectors; sum must hold the previous result while busy.
  task automatic test_wide();
    logic [15:0] va   [5];
    logic [15:0] vb   [5];
    logic        vc   [5];
    logic [16:0] vexp [5];
    logic [16:0] prev;
    bit          stable;
    va[0] = 16'hFFFF; vb[0] = 16'h0001; vc[0] = 1'b0; vexp[0] = 17'h1_0000;
    va[1] = 16'h1234; vb[1] = 16'h4321; vc[1] = 1'b1; vexp[1] = 17'h0_5556;
    va[2] = 16'h8000; vb[2] = 16'h8000; vc[2] = 1'b1; vexp[2] = 17'h1_0001;
    va[3] = 16'hABCD; vb[3] = 16'h1111; vc[3] = 1'b0; vexp[3] = 17'h0_BCDE;
    va[4] = 16'hFFFF; vb[4] = 16'hFFFF; vc[4] = 1'b1; vexp[4] = 17'h1_FFFF;
    prev = 17'h0;
    for (int i = 0; i < 5; i++) begin
      a16 = va[i]; b16 = vb[i]; cin16 = vc[i]; start16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start16 = 1'b0;
      a16 = 16'h5A5A; b16 = 16'hA5A5; cin16 = 1'b1;
      stable = 1'b1;
      for (int n = 0; n < 4; n++) begin
        if (busy16 !== 1'b1 || done16 !== 1'b0 || {cout16, sum16} !== prev) stable = 1'b0;
        @(negedge clk);
      end
      checks++;
      if (!stable) begin
        failures++;
        $display("FAIL wide_hold i=%0d got unstable outputs while busy want cout/sum=%h held", i, prev);
      end
      checks++;
      if (done16 !== 1'b1 || {cout16, sum16} !== vexp[i]) begin
        failures++;
        $display("FAIL wide_result i=%0d got done=%b cout/sum=%h want done=1 cout/sum=%h",
                 i, done16, {cout16, sum16}, vexp[i]);
      end
      prev = vexp[i];
      @(negedge clk);
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic       ts [3];
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic [9:0] texp [3];
    ts[0] = 1'b1; ta[0] = 8'h05; tb[0] = 8'h07; texp[0] = {1'b0, 1'b0, 8'hFE};
    ts[1] = 1'b1; ta[1] = 8'h80; tb[1] = 8'h01; texp[1] = {1'b1, 1'b1, 8'h7F};
    ts[2] = 1'b0; ta[2] = 8'h7F; tb[2] = 8'h01; texp[2] = {1'b1, 1'b0, 8'h80};
    for (int i = 0; i < 3; i++) begin
      sub8 = ts[i]; a8 = ta[i]; b8 = tb[i]; cin8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      sub8 = ~ts[i];
      repeat (4) @(negedge clk);
      checks++;
      if (done8 !== 1'b1 || {ovf8, cout8, sum8} !== texp[i]) begin
        failures++;
        $display("FAIL sub_result i=%0d got done=%b ovf=%b cout=%b sum=%h want done=1 ovf/cout/sum=%h",
                 i, done8, ovf8, cout8, sum8, texp[i]);
      end
      @(negedge clk);
    end
    sub8 = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 1'b0;
`endif
    test_reset();
    test_basic();
    test_half_adder();
    test_back_to_back();
    test_reset_mid_op();
    test_wide();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised multi-cycle adder, the sequential successor to the team's single-bit half adder. Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, using a registered carry between steps. It sits in datapaths where adder area matters more than latency, and uses a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and sum width in bits; must be >= 1 and an integer multiple of DIGIT.
DIGIT, 2, bits added per clock; must satisfy 1 <= DIGIT <= WIDTH.
STEPS (localparam), WIDTH/DIGIT, number of add cycles per operation.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request a new operation; sampled only while busy=0.
a  input  WIDTH  operand A; captured on an accepted start.
b  input  WIDTH  operand B; captured on an accepted start.
cin  input  1  carry-in; captured on an accepted start.
busy  output  1  high while an operation is in progress (RUN state).
done  output  1  one-cycle pulse when sum/cout become valid.
sum  output  WIDTH  registered result, held until the next completion.
cout  output  1  registered carry-out of the MSB.

Behaviour:
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, step counter and carry cleared.
- States: IDLE, RUN, DONE. Outputs are decoded from registered state only.
  - busy = (state==RUN).
  - done = (state==DONE).
- IDLE:
  - start=1 at an edge latches a, b and cin, clears the step counter, and moves to RUN.
  - start=0: remain in IDLE.
- RUN, one step per edge:
  - {c, d} = A[DIGIT-1:0] + B[DIGIT-1:0] + carry, computed at DIGIT+1 bits.
  - The DIGIT-bit result d is shifted into the partial-sum register from the MSB end.
  - A and B shift right by DIGIT; carry <= c; counter++.
  - On the edge where counter==STEPS-1: sum <= final partial sum, cout <= c, state -> DONE.
- DONE:
  - Lasts exactly one cycle (done=1), then the block returns to IDLE.
  - busy=0 in DONE, so a start seen at the DONE-exit edge is accepted and goes straight to RUN. Back-to-back throughput is therefore one result per STEPS+1 cycles.
- Latency: start accepted at edge E0; done=1 during the cycle after edge E0+STEPS; sum/cout valid from that same edge.
- sum and cout change only on entry to DONE. They stay stable through IDLE and through any later RUN until the next completion.
- start while busy=1 is ignored; a, b and cin are don't-care outside the accepting edge.
- Reset asserted mid-operation aborts the operation: no done pulse, and outputs return to their reset values.
- Arithmetic is modulo 2^WIDTH with cout as bit WIDTH. Result must equal {cout,sum} = a + b + cin.
- Degenerate case STEPS=1 (DIGIT=WIDTH): a single RUN cycle, so done appears 1 cycle after the start edge.

Optional Feature:
Macro: SERIAL_ADDER_SUB_EN
- Defined:
  - Adds input port sub (1 bit), captured together with a and b on an accepted start.
  - When sub=1, B is replaced by ~b and the initial carry by ~cin. The result is a - b - cin in two's complement, and cout=1 means no borrow.
  - Adds output ovf (1 bit, reset 0, updated on entry to DONE). ovf is the signed overflow of the WIDTH-bit add/subtract, from the carry into and out of the MSB.
- Not defined: ports sub and ovf do not exist, and the block only adds.

Test Plan:
- WIDTH=8, DIGIT=2: a=0xFF, b=0x01, cin=0, start pulse -> busy=1 for 4 cycles; done=1 in the 5th cycle after the start edge with sum=0x00, cout=1.
- WIDTH=1, DIGIT=1: loop {a,b}=0..3 with cin=0 (half-adder equivalence) -> sum/cout = 0/0, 1/0, 1/0, 0/1, each done 1 cycle after its start.
- WIDTH=8, DIGIT=2: a=0x3C, b=0x55, cin=1; hold start=1 continuously -> first result sum=0x92, cout=0. start is ignored while busy, and a new op is accepted at the DONE edge (done pulses every 5 cycles).
- Reset mid-op: rst_n=0 asynchronously during step 2 of a=0x80, b=0x80 -> busy, done, sum and cout go to 0 immediately, no done pulse follows, and the next op a=0x01, b=0x02 gives sum=0x03.
- Randomised sweep, WIDTH=16, DIGIT=4, 1000 ops -> {cout,sum} == a+b+cin every time, and sum is stable between done pulses.
- SERIAL_ADDER_SUB_EN, WIDTH=8: sub=1, a=0x05, b=0x07, cin=0 -> sum=0xFE, cout=0, ovf=0; sub=1, a=0x80, b=0x01 -> sum=0x7F, ovf=1.
